// File: rtl/fetch_target_queue_pkg.sv
// Shared configuration and BPU/FTQ bundle types for the fetch target queue.
// core_config sizes the queue; bpu_types carries the BPU-facing structs.
package core_config;
   localparam int FTQ_SIZE     = 8;
   localparam int FTQ_ID_WIDTH = $clog2(FTQ_SIZE);
   localparam int ADDR_W       = 32;
endpackage

package bpu_types;
   import core_config::*;

   localparam logic [1:0] BRANCH_TYPE_NONE = 2'd0;
   localparam logic [1:0] BRANCH_TYPE_COND = 2'd1;
   localparam logic [1:0] BRANCH_TYPE_JUMP = 2'd2;
   localparam logic [1:0] BRANCH_TYPE_RET  = 2'd3;

   localparam int FTB_IDX_W  = 4;
   localparam int BPU_META_W = 16;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] start_pc;
      logic [2:0]        length;
      logic              is_cross_cacheline;
      logic              predicted_taken;
   } ftq_block_t;

   typedef struct packed {
      logic                  ftb_hit;
      logic [FTB_IDX_W-1:0]  ftb_hit_index;
      logic [BPU_META_W-1:0] bpu_meta;
   } bpu_ftq_meta_t;

   typedef struct packed {
      logic                  valid;
      logic [ADDR_W-1:0]     start_pc;
      logic                  is_cross_cacheline;
      logic                  predicted_taken;
      logic [BPU_META_W-1:0] bpu_meta;
      logic                  ftb_hit;
      logic [FTB_IDX_W-1:0]  ftb_hit_index;
      logic                  is_taken;
      logic [1:0]            branch_type;
      logic [ADDR_W-1:0]     jump_target_address;
      logic [ADDR_W-1:0]     fall_through_address;
      logic                  ftb_dirty;
   } ftq_bpu_meta_t;
endpackage

package fetch_target_queue_pkg;
   localparam int PERF_N = 4;

   typedef enum logic [1:0] {
      PERF_FULL    = 2'd0,
      PERF_P1      = 2'd1,
      PERF_REWIND  = 2'd2,
      PERF_COMMIT  = 2'd3
   } perf_idx_e;
endpackage

// File: rtl/fetch_target_queue.sv
// Fetch target queue between BPU and IFU, with in-order commit training.
// Optional event counters on perf_o when FTQ_PERF_CNT_EN is defined.
module fetch_target_queue
   import core_config::*;
   import bpu_types::*;
   import fetch_target_queue_pkg::*;
#(
   parameter int QUEUE_SIZE = FTQ_SIZE,
   parameter int ADDR_WIDTH = ADDR_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          backend_flush_i,
   input  ftq_block_t                    bpu_p0_i,
   input  ftq_block_t                    bpu_p1_i,
   input  bpu_ftq_meta_t                 bpu_meta_i,
   output logic                          ftq_full_o,
   output ftq_block_t                    ifu_block_o,
   output logic [$clog2(QUEUE_SIZE)-1:0] ifu_id_o,
   input  logic                          ifu_accept_i,
   output logic                          ifu_flush_o,
   input  logic                          commit_valid_i,
   input  logic                          commit_is_taken_i,
   input  logic [1:0]                    commit_branch_type_i,
   input  logic [ADDR_WIDTH-1:0]         commit_jump_target_i,
   input  logic [ADDR_WIDTH-1:0]         commit_fall_through_i,
   input  logic                          commit_ftb_dirty_i,
`ifdef FTQ_PERF_CNT_EN
   output logic [PERF_N-1:0][31:0]       perf_o,
`endif
   output ftq_bpu_meta_t                 bpu_train_o
);

   localparam int IW = $clog2(QUEUE_SIZE);
   localparam int PW = IW + 1;

   ftq_block_t    entry_q [QUEUE_SIZE];
   bpu_ftq_meta_t meta_q  [QUEUE_SIZE];

   logic [PW-1:0] bpu_ptr_q, ifu_ptr_q, comm_ptr_q;
   logic [PW-1:0] bpu_last, count, comm_next;
   logic [IW-1:0] bpu_idx, last_idx, ifu_idx, comm_idx;
   logic          p0_en, p0_en_q, p1_ok, rewind;
   logic          ifu_valid, accept, full;
   ftq_bpu_meta_t train_d;

   assign bpu_last  = bpu_ptr_q - 1'b1;
   assign count     = bpu_ptr_q - comm_ptr_q;
   assign comm_next = comm_ptr_q + PW'(commit_valid_i);
   assign bpu_idx   = bpu_ptr_q[IW-1:0];
   assign last_idx  = bpu_last[IW-1:0];
   assign ifu_idx   = ifu_ptr_q[IW-1:0];
   assign comm_idx  = comm_ptr_q[IW-1:0];

   assign full      = (count == PW'(QUEUE_SIZE));
   assign ifu_valid = (ifu_ptr_q != bpu_ptr_q);
   assign accept    = ifu_accept_i & ifu_valid;

   // An override with nothing outstanding targets a retired entry; drop it.
   assign p1_ok  = bpu_p1_i.valid & ~backend_flush_i & (count != '0);
   assign p0_en  = bpu_p0_i.valid & ~full & ~bpu_p1_i.valid
                 & ~backend_flush_i;
   assign rewind = p1_ok & (ifu_ptr_q == bpu_ptr_q);

   assign ftq_full_o = full;
   assign ifu_id_o   = ifu_idx;

   always_comb begin
      ifu_block_o       = entry_q[ifu_idx];
      ifu_block_o.valid = ifu_valid;
   end

   always_comb begin
      train_d = '0;
      if (commit_valid_i) begin
         train_d.valid                = 1'b1;
         train_d.start_pc             = entry_q[comm_idx].start_pc;
         train_d.is_cross_cacheline   = entry_q[comm_idx].is_cross_cacheline;
         train_d.predicted_taken      = entry_q[comm_idx].predicted_taken;
         train_d.bpu_meta             = meta_q[comm_idx].bpu_meta;
         train_d.ftb_hit              = meta_q[comm_idx].ftb_hit;
         train_d.ftb_hit_index        = meta_q[comm_idx].ftb_hit_index;
         train_d.is_taken             = commit_is_taken_i;
         train_d.branch_type          = commit_branch_type_i;
         train_d.jump_target_address  = commit_jump_target_i;
         train_d.fall_through_address = commit_fall_through_i;
         train_d.ftb_dirty            = commit_ftb_dirty_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         bpu_ptr_q   <= '0;
         ifu_ptr_q   <= '0;
         comm_ptr_q  <= '0;
         p0_en_q     <= 1'b0;
         ifu_flush_o <= 1'b0;
         bpu_train_o <= '0;
         for (int i = 0; i < QUEUE_SIZE; i++) begin
            entry_q[i] <= '0;
            meta_q[i]  <= '0;
         end
      end else begin
         p0_en_q     <= p0_en;
         ifu_flush_o <= rewind;
         bpu_train_o <= train_d;
         comm_ptr_q  <= comm_next;

         if (p1_ok) begin
            entry_q[last_idx] <= bpu_p1_i;
         end else if (p0_en) begin
            entry_q[bpu_idx] <= bpu_p0_i;
         end
         // Meta for a block arrives one cycle after its P0 enqueue.
         if (p1_ok | p0_en_q) begin
            meta_q[last_idx] <= bpu_meta_i;
         end
         if (commit_valid_i) begin
            entry_q[comm_idx].valid <= 1'b0;
         end

         if (backend_flush_i) begin
            bpu_ptr_q <= comm_next;
            ifu_ptr_q <= comm_next;
         end else begin
            if (p0_en) begin
               bpu_ptr_q <= bpu_ptr_q + 1'b1;
            end
            if (rewind) begin
               ifu_ptr_q <= bpu_last;
            end else if (accept) begin
               ifu_ptr_q <= ifu_ptr_q + 1'b1;
            end
         end
      end
   end

`ifdef FTQ_PERF_CNT_EN
   logic [PERF_N-1:0][31:0] perf_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         perf_q <= '0;
      end else begin
         perf_q[PERF_FULL]   <= perf_q[PERF_FULL]   + 32'(full);
         perf_q[PERF_P1]     <= perf_q[PERF_P1]     + 32'(p1_ok);
         perf_q[PERF_REWIND] <= perf_q[PERF_REWIND] + 32'(rewind);
         perf_q[PERF_COMMIT] <= perf_q[PERF_COMMIT] + 32'(commit_valid_i);
      end
   end

   assign perf_o = perf_q;
`endif

`ifdef SIMULATION
   p1_on_empty: assert property (@(posedge clk) disable iff (!rst)
      !(bpu_p1_i.valid && !backend_flush_i && count == '0));
   commit_unissued: assert property (@(posedge clk) disable iff (!rst)
      !(commit_valid_i && comm_ptr_q == ifu_ptr_q));
`endif

endmodule

// File: tb/tb_fetch_target_queue.sv
// Directed bench for fetch_target_queue: fill/full, P1 override and
// rewind, commit training, flush with commit, and pointer wrap-around.
module tb_fetch_target_queue;
   import core_config::*;
   import bpu_types::*;
   import fetch_target_queue_pkg::*;

   logic          clk = 1'b0;
   logic          rst;
   logic          backend_flush_i;
   ftq_block_t    bpu_p0_i, bpu_p1_i, ifu_block_o;
   bpu_ftq_meta_t bpu_meta_i;
   logic          ftq_full_o, ifu_accept_i, ifu_flush_o;
   logic [2:0]    ifu_id_o;
   logic          commit_valid_i, commit_is_taken_i, commit_ftb_dirty_i;
   logic [1:0]    commit_branch_type_i;
   logic [31:0]   commit_jump_target_i, commit_fall_through_i;
   ftq_bpu_meta_t bpu_train_o;
`ifdef FTQ_PERF_CNT_EN
   logic [PERF_N-1:0][31:0] perf_o;
`endif

   int total = 0;
   int bad   = 0;

   fetch_target_queue dut (
      .clk                   (clk),
      .rst                   (rst),
      .backend_flush_i       (backend_flush_i),
      .bpu_p0_i              (bpu_p0_i),
      .bpu_p1_i              (bpu_p1_i),
      .bpu_meta_i            (bpu_meta_i),
      .ftq_full_o            (ftq_full_o),
      .ifu_block_o           (ifu_block_o),
      .ifu_id_o              (ifu_id_o),
      .ifu_accept_i          (ifu_accept_i),
      .ifu_flush_o           (ifu_flush_o),
      .commit_valid_i        (commit_valid_i),
      .commit_is_taken_i     (commit_is_taken_i),
      .commit_branch_type_i  (commit_branch_type_i),
      .commit_jump_target_i  (commit_jump_target_i),
      .commit_fall_through_i (commit_fall_through_i),
      .commit_ftb_dirty_i    (commit_ftb_dirty_i),
`ifdef FTQ_PERF_CNT_EN
      .perf_o                (perf_o),
`endif
      .bpu_train_o           (bpu_train_o)
   );

   always #5 clk = ~clk;

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic ftq_block_t blk(logic [31:0] pc, logic [2:0] len,
                                      logic tk);
      ftq_block_t b;
      b = '0;
      b.valid = 1'b1;
      b.start_pc = pc;
      b.length = len;
      b.predicted_taken = tk;
      return b;
   endfunction

   task automatic idle();
      backend_flush_i       = 1'b0;
      bpu_p0_i              = '0;
      bpu_p1_i              = '0;
      bpu_meta_i            = '0;
      ifu_accept_i          = 1'b0;
      commit_valid_i        = 1'b0;
      commit_is_taken_i     = 1'b0;
      commit_branch_type_i  = BRANCH_TYPE_NONE;
      commit_jump_target_i  = '0;
      commit_fall_through_i = '0;
      commit_ftb_dirty_i    = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   bpu_ftq_meta_t m [3];

   initial begin
      rst = 1'b0;
      idle();

      // reset state
      do_reset();
      check("rst_full", ftq_full_o, 0);
      check("rst_ifu_v", ifu_block_o.valid, 0);
      check("rst_flush", ifu_flush_o, 0);
      check("rst_train_v", bpu_train_o.valid, 0);

      // fill to full without accepting
      for (int i = 0; i < 8; i++) begin
         bpu_p0_i = blk(32'h1c00_0000 + 32'(16 * i), 3'd4, 1'b0);
         tick();
         check($sformatf("fill_full%0d", i), ftq_full_o, (i == 7));
      end
      bpu_p0_i = blk(32'h1c00_0080, 3'd4, 1'b0);
      tick();
      check("ninth_full", ftq_full_o, 1);
      for (int k = 0; k < 8; k++) begin
         check($sformatf("drain_v%0d", k), ifu_block_o.valid, 1);
         check($sformatf("drain_pc%0d", k), ifu_block_o.start_pc,
               32'h1c00_0000 + 32'(16 * k));
         check($sformatf("drain_id%0d", k), ifu_id_o, k);
         ifu_accept_i = 1'b1;
         tick();
      end
      check("ninth_dropped", ifu_block_o.valid, 0);

      // P1 override of an unissued block
      do_reset();
      bpu_p0_i = blk(32'h1000, 3'd0, 1'b0);
      tick();
      m[0] = '{ftb_hit: 1'b1, ftb_hit_index: 4'h5, bpu_meta: 16'hbeef};
      bpu_p1_i = blk(32'h1000, 3'd2, 1'b1);
      bpu_p0_i = blk(32'h1010, 3'd0, 1'b0);
      bpu_meta_i = m[0];
      tick();
      check("p1_v", ifu_block_o.valid, 1);
      check("p1_pc", ifu_block_o.start_pc, 32'h1000);
      check("p1_len", ifu_block_o.length, 2);
      check("p1_tk", ifu_block_o.predicted_taken, 1);
      check("p1_noflush", ifu_flush_o, 0);
      ifu_accept_i = 1'b1;
      tick();
      check("p1_p0_dropped", ifu_block_o.valid, 0);
      commit_valid_i = 1'b1;
      tick();
      check("p1_train_v", bpu_train_o.valid, 1);
      check("p1_train_pc", bpu_train_o.start_pc, 32'h1000);
      check("p1_train_tk", bpu_train_o.predicted_taken, 1);
      check("p1_train_meta", bpu_train_o.bpu_meta, 16'hbeef);
      check("p1_train_idx", bpu_train_o.ftb_hit_index, 4'h5);
      check("p1_train_hit", bpu_train_o.ftb_hit, 1);

      // P1 override of an issued block rewinds the IFU
      do_reset();
      bpu_p0_i = blk(32'h2000, 3'd1, 1'b0);
      tick();
      ifu_accept_i = 1'b1;
      tick();
      check("rw_issued", ifu_block_o.valid, 0);
      bpu_p1_i = blk(32'h2000, 3'd5, 1'b0);
      tick();
      check("rw_flush", ifu_flush_o, 1);
      check("rw_v", ifu_block_o.valid, 1);
      check("rw_id", ifu_id_o, 0);
      check("rw_pc", ifu_block_o.start_pc, 32'h2000);
      check("rw_len", ifu_block_o.length, 5);
      tick();
      check("rw_flush_pulse", ifu_flush_o, 0);
      check("rw_still_v", ifu_block_o.valid, 1);

      // commit training
      do_reset();
      m[0] = '{ftb_hit: 1'b1, ftb_hit_index: 4'h1, bpu_meta: 16'h0a0a};
      m[1] = '{ftb_hit: 1'b0, ftb_hit_index: 4'h2, bpu_meta: 16'h0b0b};
      m[2] = '{ftb_hit: 1'b1, ftb_hit_index: 4'h3, bpu_meta: 16'h0c0c};
      for (int i = 0; i < 4; i++) begin
         if (i < 3) bpu_p0_i = blk(32'h4000 + 32'(16 * i), 3'd3, 1'b0);
         if (i > 0) bpu_meta_i = m[i-1];
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         ifu_accept_i = 1'b1;
         tick();
      end
      commit_valid_i        = 1'b1;
      commit_is_taken_i     = 1'b1;
      commit_branch_type_i  = BRANCH_TYPE_COND;
      commit_jump_target_i  = 32'h3000;
      commit_fall_through_i = 32'h4010;
      commit_ftb_dirty_i    = 1'b1;
      tick();
      check("cm_v", bpu_train_o.valid, 1);
      check("cm_pc", bpu_train_o.start_pc, 32'h4000);
      check("cm_taken", bpu_train_o.is_taken, 1);
      check("cm_type", bpu_train_o.branch_type, BRANCH_TYPE_COND);
      check("cm_tgt", bpu_train_o.jump_target_address, 32'h3000);
      check("cm_ft", bpu_train_o.fall_through_address, 32'h4010);
      check("cm_dirty", bpu_train_o.ftb_dirty, 1);
      check("cm_meta0", bpu_train_o.bpu_meta, 16'h0a0a);
      commit_valid_i       = 1'b1;
      commit_branch_type_i = BRANCH_TYPE_JUMP;
      tick();
      check("cm1_pc", bpu_train_o.start_pc, 32'h4010);
      check("cm1_taken", bpu_train_o.is_taken, 0);
      check("cm1_type", bpu_train_o.branch_type, BRANCH_TYPE_JUMP);
      check("cm1_meta", bpu_train_o.bpu_meta, 16'h0b0b);
      check("cm1_hit", bpu_train_o.ftb_hit, 0);
      tick();
      check("cm_idle_v", bpu_train_o.valid, 0);

      // flush together with a commit
      do_reset();
      for (int i = 0; i < 5; i++) begin
         bpu_p0_i = blk(32'h5000 + 32'(16 * i), 3'd2, 1'b0);
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         ifu_accept_i = 1'b1;
         tick();
      end
      commit_valid_i  = 1'b1;
      backend_flush_i = 1'b1;
      bpu_p0_i        = blk(32'h9990, 3'd1, 1'b0);
      tick();
      check("fl_train_v", bpu_train_o.valid, 1);
      check("fl_train_pc", bpu_train_o.start_pc, 32'h5000);
      check("fl_ifu_v", ifu_block_o.valid, 0);
      check("fl_full", ftq_full_o, 0);
      bpu_p0_i = blk(32'h6000, 3'd2, 1'b0);
      tick();
      check("fl_re_v", ifu_block_o.valid, 1);
      check("fl_re_id", ifu_id_o, 1);
      check("fl_re_pc", ifu_block_o.start_pc, 32'h6000);

      // wrap: enqueue, accept and commit overlapped
      do_reset();
      for (int i = 0; i < 22; i++) begin
         if (i >= 1 && i <= 20) begin
            check($sformatf("wr_v%0d", i), ifu_block_o.valid, 1);
            check($sformatf("wr_pc%0d", i), ifu_block_o.start_pc,
                  32'h7000 + 32'(16 * (i - 1)));
            check($sformatf("wr_id%0d", i), ifu_id_o, (i - 1) % 8);
         end
         if (i >= 3) begin
            check($sformatf("wr_tr%0d", i), bpu_train_o.start_pc,
                  32'h7000 + 32'(16 * (i - 3)));
         end
         check($sformatf("wr_full%0d", i), ftq_full_o, 0);
         if (i < 20) bpu_p0_i = blk(32'h7000 + 32'(16 * i), 3'd1, 1'b0);
         if (i >= 1 && i <= 20) ifu_accept_i = 1'b1;
         if (i >= 2) commit_valid_i = 1'b1;
         tick();
      end
      check("wr_last_tr", bpu_train_o.start_pc, 32'h7000 + 32'(16 * 19));
      check("wr_last_trv", bpu_train_o.valid, 1);
      check("wr_empty", ifu_block_o.valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
